// File: rtl/gpu_cmd_queue.sv
// CPU-side command FIFO that replays {opcode, operand} pairs to the gpu with a glitch-free strobe.
// Optional: define GPU_CMD_VSYNC_GATE_EN to hold display/swap commands until vblank.
module gpu_cmd_queue #(
    parameter int DEPTH         = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [1:0]               wr_op,
    input  logic [7:0]               wr_data,
    input  logic                     vblank,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy,
    output logic [1:0]               interrupt_in,
    output logic [7:0]               data_in,
    output logic                     interrupt_enable
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ie;
    logic [1:0]    r_op;
    logic [7:0]    r_data;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_ie_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_elig;
    logic [9:0]    w_head;

    assign w_head = r_mem[r_rptr];
    assign full   = (r_level == (AW+1)'(DEPTH));
    assign empty  = (r_level == '0);
    assign w_push = wr_en && !full;

`ifdef GPU_CMD_VSYNC_GATE_EN
    // A swap at the head blocks everything behind it until vblank.
    assign w_elig = !empty && ((w_head[9:8] != 2'b10) || vblank);
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_elig = !empty;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ie_nxt    = r_ie;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_elig) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
                    w_ie_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STROBE: begin
                if (r_cnt == CW'(STROBE_CYCLES - 1)) begin
                    w_ie_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (w_elig) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {wr_op, wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (wr_en && full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ie    <= 1'b0;
            r_op    <= 2'b00;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ie    <= w_ie_nxt;
            if (w_pop) begin
                r_op   <= w_head[9:8];
                r_data <= w_head[7:0];
            end
        end
    end

    assign level            = r_level;
    assign overflow         = r_ovf;
    assign busy             = (r_state != S_IDLE);
    assign interrupt_in     = r_op;
    assign data_in          = r_data;
    assign interrupt_enable = r_ie;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Bench for gpu_cmd_queue: directed steps plus random traffic against a cycle-level queue model.
// The model follows GPU_CMD_VSYNC_GATE_EN the same way the design build does.
module tb_gpu_cmd_queue;

    localparam int DEPTH = 16;
    localparam int PERIOD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_op = 2'b00;
    logic [7:0] wr_data = 8'h00;
    logic       vblank = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       busy;
    logic [1:0] interrupt_in;
    logic [7:0] data_in;
    logic       interrupt_enable;

    gpu_cmd_queue #(.DEPTH(DEPTH), .SETUP_CYCLES(1), .STROBE_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .wr_op            (wr_op),
        .wr_data          (wr_data),
        .vblank           (vblank),
        .full             (full),
        .empty            (empty),
        .level            (level),
        .overflow         (overflow),
        .busy             (busy),
        .interrupt_in     (interrupt_in),
        .data_in          (data_in),
        .interrupt_enable (interrupt_enable)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail = 0;
    logic [9:0] mq[$];
    int         cyc = 0;
    int         last_pop = -100;
    logic       m_ovf = 1'b0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int d;
        d = cyc - last_pop;
        chk("level", 32'(level), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(d < PERIOD));
        chk("strobe", 32'(interrupt_enable), 32'(d == 1 || d == 2));
        chk("opcode", 32'(interrupt_in), 32'(m_op));
        chk("operand", 32'(data_in), 32'(m_data));
    endtask

    // One clock: model consumes pre-edge inputs, DUT checked 1ns after the edge.
    task automatic tick();
        int         pre;
        logic       elig;
        logic [9:0] e;
        pre  = mq.size();
        elig = (pre > 0) && (cyc >= last_pop + PERIOD);
`ifdef GPU_CMD_VSYNC_GATE_EN
        if (pre > 0 && mq[0][9:8] == 2'b10 && !vblank) elig = 1'b0;
`endif
        if (wr_en && pre == DEPTH) m_ovf = 1'b1;
        if (elig) begin
            e = mq.pop_front();
            m_op = e[9:8];
            m_data = e[7:0];
            last_pop = cyc;
        end
        if (wr_en && pre < DEPTH) mq.push_back({wr_op, wr_data});
        @(posedge clk);
        #1;
        check_all();
        cyc++;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_strobe", 32'(interrupt_enable), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        mq.delete();
        cyc = 0;
        last_pop = -100;
        m_ovf = 1'b0;
        m_op = 2'b00;
        m_data = 8'h00;
        check_all();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // single store byte
        wr_en = 1'b1; wr_op = 2'b00; wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        repeat (6) tick();

        // burst faster than drain: fills and overflows
        do_reset();
        for (int i = 0; i < 24; i++) begin
            wr_en = 1'b1;
            wr_op = 2'($urandom);
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        chk("ovf_sticky", 32'(overflow), 32'd1);
        repeat (70) tick();

        // reset while strobing with 3 entries queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_op = 2'(i);
            wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        #2;
        chk("pre_rst_strobe", 32'(interrupt_enable), 32'd1);
        chk("pre_rst_level", 32'(level), 32'd3);
        do_reset();
        repeat (10) tick();

        // swap followed by store, vblank low then high
        vblank = 1'b0;
        wr_en = 1'b1; wr_op = 2'b10; wr_data = 8'h00;
        tick();
        wr_op = 2'b00; wr_data = 8'h42;
        tick();
        wr_en = 1'b0;
        repeat (6) tick();
        vblank = 1'b1;
        repeat (10) tick();

        // random traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            wr_en = ($urandom_range(0, 2) != 0);
            wr_op = 2'($urandom);
            wr_data = 8'($urandom);
            vblank = 1'($urandom);
            tick();
        end
        wr_en = 1'b0;
        vblank = 1'b1;
        repeat (80) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_cmd_queue.md
# gpu_cmd_queue

CPU-side command queue that sits directly upstream of the `gpu` text-mode block. It buffers 2-bit opcode / 8-bit operand pairs written by the CPU bus in a FIFO. It replays each command to the gpu's `interrupt_in`/`data_in` inputs with a clean, fully-timed `interrupt_enable` pulse. Because the gpu samples commands on the rising edge of `interrupt_enable`, this block guarantees setup and hold of opcode/operand around that edge and never glitches the strobe.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `SETUP_CYCLES`, 1: cycles opcode/operand are stable before `interrupt_enable` rises; ≥ 1.
- `STROBE_CYCLES`, 2: cycles `interrupt_enable` stays high; ≥ 1.

- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: push request, sampled on `clk`.
- `wr_op` in 2: opcode (00 store byte, 01 move cursor, 10 display/swap, 11 clear).
- `wr_data` in 8: operand.
- `vblank` in 1: high during vertical blanking; used only with `GPU_CMD_VSYNC_GATE_EN`.
- `full` out 1: FIFO holds `DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries.
- `level` out $clog2(DEPTH)+1: current entry count.
- `overflow` out 1: sticky; set when a push is dropped.
- `busy` out 1: FSM not in IDLE.
- `interrupt_in` out 2: opcode to gpu.
- `data_in` out 8: operand to gpu.
- `interrupt_enable` out 1: command strobe to gpu; registered output.

## Operation
- FIFO: 10-bit entries {op, data}; wrapping read/write pointers of $clog2(DEPTH) bits; `level` is a registered counter.
- Push accepted iff `wr_en` && !`full` (pre-edge value). A push while `full` is dropped and sets `overflow`, regardless of a simultaneous pop. `overflow` clears only on `rst`.
- Same-edge push and pop: `level` is unchanged and both pointers advance.
- FSM states:
  - IDLE: if the head entry is eligible, pop it, load `interrupt_in`/`data_in`, clear the counter, and go to SETUP.
  - SETUP: counts `SETUP_CYCLES`, then raises `interrupt_enable` and goes to STROBE.
  - STROBE: counts `STROBE_CYCLES`, then lowers `interrupt_enable` and goes to HOLD.
  - HOLD: one cycle; opcode/operand stay unchanged. If the head entry is eligible, pop it and go directly to SETUP; otherwise go to IDLE.
- Eligible: !`empty` (plus the gate under Configuration).
- `interrupt_in`/`data_in` change only on a pop and hold their value until the next pop; they are never changed while `interrupt_enable` is high.
- `busy` = state != IDLE.

## Timing
- Reset values: `interrupt_enable`=0, `interrupt_in`=0, `data_in`=0, `overflow`=0, `busy`=0, `empty`=1, `full`=0, `level`=0; FSM in IDLE; pointers at 0.
- Reset is asynchronous. Asserting `rst` mid-STROBE drops `interrupt_enable` immediately and discards all queued entries.
- Push at edge N into an empty, idle queue:
  - `empty` falls after N.
  - Pop at N+1; `interrupt_in`/`data_in` valid after N+1.
  - `interrupt_enable` high after N+1+`SETUP_CYCLES`.
  - `interrupt_enable` low after N+1+`SETUP_CYCLES`+`STROBE_CYCLES`.
- Back-to-back throughput: one command per `SETUP_CYCLES`+`STROBE_CYCLES`+1 cycles (4 at defaults).
- `full`/`empty`/`level` update on the edge after push/pop.

## Configuration
- `GPU_CMD_VSYNC_GATE_EN` defined: a head entry with op 10 (display/swap) is eligible only while `vblank`=1. Other opcodes are unaffected. Commands behind a gated swap stay queued (strict order is kept), and the FSM waits in IDLE.
- Not defined: `vblank` is ignored and every non-empty head is eligible.

## Test plan
- Reset, then push {00, 0x41} at cycle 0 → `interrupt_in`=00 and `data_in`=0x41 after edge 1; `interrupt_enable` high during cycles 2–3 and low at 4; `level` returns to 0.
- Push 16 entries back-to-back, then a 17th while idle is blocked by a held gate (or with pushes faster than drain) → `full`=1, 17th dropped, `overflow`=1. All 16 emerge in order with strobes every 4 cycles.
- Push and pop on the same edge at `level`=5 → `level` stays 5 and no entry is lost or duplicated.
- Assert `rst` during STROBE with 3 entries queued → `interrupt_enable`=0 immediately; `empty`=1, `level`=0, and no further strobes.
- With `GPU_CMD_VSYNC_GATE_EN`, `vblank`=0: queue {10,0x00},{00,0x42} → no strobe. Raise `vblank` → swap strobe, then store strobe 4 cycles later.
- Without the macro, same stimulus → both strobes issue immediately regardless of `vblank`.
